bcd_display_scan: RTL and testbench
===================================

# bcd_display_scan

Read-side counterpart of the keypad digit-entry register block. The entry block shifts BCD digits into 16-bit operand registers; this block takes a 16-bit packed BCD value plus sign and drives a 4-digit multiplexed 7-segment display. It scans one digit per refresh slot, blanks leading zeros, and places a minus sign next to the most significant digit. New values are double-buffered and applied only at frame boundaries, so a frame never mixes old and new digits.

## Interface
- REFRESH_DIV, 50000, clock cycles per digit slot; legal range 1..2^20; counter width is $clog2(REFRESH_DIV), minimum 1
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- load  in  1  single-cycle strobe; captures bcd/neg into shadow register
- bcd  in  16  packed BCD, [3:0] = units (digit 0), [15:12] = digit 3
- neg  in  1  sign of bcd, captured with load
- pending  out  1  shadow holds a value not yet displayed
- an  out  4  digit enables, one-hot active-low, an[i] = digit i
- seg  out  7  segments active-high, seg[6]=a … seg[0]=g
- dp  out  1  decimal point, active-high

## Operation
- Registers: slot counter (0..REFRESH_DIV-1), digit index (0..3), shadow {bcd,neg}, display {bcd,neg}, pending.
- Slot counter increments every cycle and wraps at REFRESH_DIV-1 (terminal count, TC). On TC the index increments mod 4. Scan order is digit 0,1,2,3.
- Frame boundary: TC with index==3.
- load=1: shadow <= {bcd,neg}; pending <= 1.
- At a frame boundary with pending=1: display <= shadow; pending <= 0.
- load in the boundary cycle: the display takes the old shadow, the new value goes into the shadow, and pending stays 1. The new value is applied at the next boundary.
- Segment codes: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B; nibble A–F = 4F ("E"); minus = 01; blank = 00.
- Leading-zero blanking (LZ_BLANK_EN):
  - MSD = the highest nonzero digit; MSD = 0 when the value is zero.
  - Digits above the MSD are blank.
  - An invalid nibble (A–F) counts as nonzero.
- Sign display:
  - If display neg=1 and the value is nonzero: the digit at MSD+1 shows minus.
  - If MSD==3: dp is lit on digit 3 instead.
  - A value of zero is never shown as negative.
- dp is 0 in every other case.

## Timing
- Reset values: an=4'b1111, seg=7'h00, dp=0, pending=0, shadow=0, display=0, index=0, slot=0.
- Outputs an/seg/dp are registered decodes of the index and display values as they stood after the previous edge.
- First rising edge after reset release: an=1110 showing digit 0. Each digit then stays enabled for REFRESH_DIV cycles. Frame length is 4·REFRESH_DIV cycles.
- At the boundary edge, the index wraps to 0 and the display register updates. The new value appears on seg one edge later.
- load-to-display latency: worst case 4·REFRESH_DIV+1 cycles; best case 2 cycles (load in the cycle before the boundary).
- pending rises on the edge after load and falls on the boundary edge.
- REFRESH_DIV=1: the index advances every cycle and every fourth cycle is a boundary.
- Reset mid-frame clears everything asynchronously; outputs go to reset values without waiting for a clock edge.

## Configuration
- LZ_BLANK_EN defined:
  - Leading-zero blanking as described.
  - Minus sign placed at MSD+1, or dp on digit 3 when MSD==3.
- LZ_BLANK_EN undefined:
  - All four digits always show their code; no blanking and no minus segment pattern.
  - Negative nonzero values are shown only by dp=1 on digit 3.

## Test plan
All scenarios use REFRESH_DIV=4 with LZ_BLANK_EN defined unless noted.
- Reset held, then released:
  - an=1111, seg=00, dp=0, pending=0 during reset.
  - After release, an runs 1110,1101,1011,0111, each for 4 cycles; seg=7E on digit 0 and 00 on digits 1–3.
- load bcd=16'h1234, neg=0 mid-frame:
  - pending=1 until the next boundary, then 0.
  - Next frame shows digits 0..3 = 33, 79, 6D, 30; dp=0.
- load bcd=16'h0050, neg=1: digit 0=7E, digit 1=5B, digit 2=01, digit 3=00.
- load bcd=16'h0000, neg=1: digit 0=7E, others 00, dp=0.
- load bcd=16'h9A99, neg=1: digits = 7B, 7B, 4F, 7B; dp=1 on digit 3 only.
- load in the boundary cycle:
  - Old shadow is displayed; pending stays 1; the new value appears one frame later.
  - Reset asserted mid-frame immediately forces all reset values.

Source files
------------

// File: rtl/bcd_display_scan.sv
// Scans a double-buffered 16-bit packed BCD value plus sign onto a 4-digit
// multiplexed 7-segment display. Define LZ_BLANK_EN for leading-zero blanking.
module bcd_display_scan #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] bcd,
  input  logic        neg,
  output logic        pending,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] slot_q, slot_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_bcd_q, shadow_bcd_d;
  logic          shadow_neg_q, shadow_neg_d;
  logic [15:0]   disp_bcd_q, disp_bcd_d;
  logic          disp_neg_q, disp_neg_d;
  logic          pending_q, pending_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tc;
  logic          boundary;
  logic [3:0]    digit;
  logic          show_neg;
`ifdef LZ_BLANK_EN
  logic [1:0]    msd;
`endif

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'd0:    seg_code = 7'h7E;
      4'd1:    seg_code = 7'h30;
      4'd2:    seg_code = 7'h6D;
      4'd3:    seg_code = 7'h79;
      4'd4:    seg_code = 7'h33;
      4'd5:    seg_code = 7'h5B;
      4'd6:    seg_code = 7'h5F;
      4'd7:    seg_code = 7'h70;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h7B;
      default: seg_code = 7'h4F;
    endcase
  endfunction

  always_comb begin
    tc       = (slot_q == SLOT_LAST);
    boundary = tc && (idx_q == 2'd3);

    slot_d = tc ? '0 : slot_q + CW'(1);
    idx_d  = tc ? idx_q + 2'd1 : idx_q;

    // The display copies the shadow as it stood before any same-cycle load,
    // so a load on the boundary is deferred by one whole frame.
    shadow_bcd_d = shadow_bcd_q;
    shadow_neg_d = shadow_neg_q;
    disp_bcd_d   = disp_bcd_q;
    disp_neg_d   = disp_neg_q;
    pending_d    = pending_q;
    if (boundary && pending_q) begin
      disp_bcd_d = shadow_bcd_q;
      disp_neg_d = shadow_neg_q;
      pending_d  = 1'b0;
    end
    if (load) begin
      shadow_bcd_d = bcd;
      shadow_neg_d = neg;
      pending_d    = 1'b1;
    end

    digit    = disp_bcd_q[{idx_q, 2'b00} +: 4];
    show_neg = disp_neg_q && (disp_bcd_q != 16'h0000);
    an_d     = ~(4'b0001 << idx_q);

`ifdef LZ_BLANK_EN
    msd = 2'd0;
    for (int unsigned i = 1; i < 4; i++) begin
      if (disp_bcd_q[4*i +: 4] != 4'h0) msd = 2'(i);
    end
    if (idx_q > msd) begin
      seg_d = (show_neg && (idx_q == msd + 2'd1)) ? 7'h01 : 7'h00;
    end else begin
      seg_d = seg_code(digit);
    end
    dp_d = show_neg && (msd == 2'd3) && (idx_q == 2'd3);
`else
    seg_d = seg_code(digit);
    dp_d  = show_neg && (idx_q == 2'd3);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q       <= '0;
      idx_q        <= '0;
      shadow_bcd_q <= '0;
      shadow_neg_q <= 1'b0;
      disp_bcd_q   <= '0;
      disp_neg_q   <= 1'b0;
      pending_q    <= 1'b0;
      an_q         <= '1;
      seg_q        <= '0;
      dp_q         <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_neg_q <= shadow_neg_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_neg_q   <= disp_neg_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign pending = pending_q;
  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = dp_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with REFRESH_DIV=4; expectations follow
// whether LZ_BLANK_EN is defined for the build.
module tb_bcd_display_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] bcd = '0;
  logic        neg = 1'b0;
  logic        pending;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned pend_cycles;

`ifdef LZ_BLANK_EN
  localparam logic [6:0] BLK = 7'h00;
  localparam logic [6:0] MIN = 7'h01;
  localparam logic       NEG_DP_SMALL = 1'b0;
`else
  localparam logic [6:0] BLK = 7'h7E;
  localparam logic [6:0] MIN = 7'h7E;
  localparam logic       NEG_DP_SMALL = 1'b1;
`endif

  bcd_display_scan #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .bcd     (bcd),
    .neg     (neg),
    .pending (pending),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts at the negedge just after a boundary (or reset release) edge.
  task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3, input logic dp3);
    logic [6:0] e [4];
    logic [3:0] ea;
    e = '{s0, s1, s2, s3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ea = ~(4'b0001 << i);
      check($sformatf("%s_an%0d", tag, i), 32'(an), 32'(ea));
      check($sformatf("%s_seg%0d", tag, i), 32'(seg), 32'(e[i]));
      check($sformatf("%s_dp%0d", tag, i), 32'(dp), (i == 3) ? 32'(dp3) : 32'd0);
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic do_load(input string tag, input logic [15:0] v, input logic s);
    @(negedge clk);
    bcd  = v;
    neg  = s;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check({tag, "_pend_set"}, 32'(pending), 32'd1);
  endtask

  task automatic wait_fall(input string tag, output int unsigned n);
    n = 0;
    while (pending && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (pending) check({tag, "_pend_timeout"}, 32'(pending), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_dp", 32'(dp), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    reset = 1'b0;
    check_frame("zero", 7'h7E, BLK, BLK, BLK, 1'b0);
    check("zero_pend", 32'(pending), 32'd0);

    do_load("v1234", 16'h1234, 1'b0);
    wait_fall("v1234", pend_cycles);
    check("v1234_pend_len", pend_cycles, 32'd14);
    check_frame("v1234", 7'h33, 7'h79, 7'h6D, 7'h30, 1'b0);

    do_load("v0050n", 16'h0050, 1'b1);
    wait_fall("v0050n", pend_cycles);
    check_frame("v0050n", 7'h7E, 7'h5B, MIN, BLK, NEG_DP_SMALL);

    do_load("v0000n", 16'h0000, 1'b1);
    wait_fall("v0000n", pend_cycles);
    check_frame("v0000n", 7'h7E, BLK, BLK, BLK, 1'b0);

    do_load("v9A99n", 16'h9A99, 1'b1);
    wait_fall("v9A99n", pend_cycles);
    check_frame("v9A99n", 7'h7B, 7'h7B, 7'h4F, 7'h7B, 1'b1);

    do_load("v0007", 16'h0007, 1'b0);
    wait_fall("v0007", pend_cycles);
    check_frame("v0007", 7'h70, BLK, BLK, BLK, 1'b0);

    // B loaded mid-frame, then C loaded exactly on the next boundary edge.
    do_load("v0300", 16'h0300, 1'b0);
    repeat (13) @(negedge clk);
    bcd  = 16'h0018;
    neg  = 1'b0;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("bnd_pend_stays", 32'(pending), 32'd1);
    check_frame("bnd_old", 7'h7E, 7'h7E, 7'h79, BLK, 1'b0);
    check("bnd_pend_fall", 32'(pending), 32'd0);
    check_frame("bnd_new", 7'h7F, 7'h30, BLK, BLK, 1'b0);

    do_load("pre_rst", 16'h5555, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_an", 32'(an), 32'hF);
    check("arst_seg", 32'(seg), 32'h0);
    check("arst_dp", 32'(dp), 32'd0);
    check("arst_pend", 32'(pending), 32'd0);
    repeat (2) @(negedge clk);
    check("arst_hold_an", 32'(an), 32'hF);
    reset = 1'b0;
    check_frame("post_rst", 7'h7E, BLK, BLK, BLK, 1'b0);
    check("post_rst_pend", 32'(pending), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
